// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/start request and product/status response between control FSM and multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
    logic                 busy;

    modport master (
        output start, multiplicand, multiplier,
        input  product, done, busy
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, done, busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier, WIDTH run cycles per product.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_add_multiplier_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_state;
    logic [PW-1:0]   r_acc, w_acc;
    logic [PW-1:0]   r_mcand, w_mcand;
    logic [WIDTH-1:0] r_mplier, w_mplier;
    logic [CW-1:0]   r_count, w_count;
    logic [PW-1:0]   r_product, w_product;
    logic            r_done, w_done;
    logic            r_busy, w_busy;
    logic [PW-1:0]   w_sum;

    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_acc     <= w_acc;
            r_mcand   <= w_mcand;
            r_mplier  <= w_mplier;
            r_count   <= w_count;
            r_product <= w_product;
            r_done    <= w_done;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_acc     = r_acc;
        w_mcand   = r_mcand;
        w_mplier  = r_mplier;
        w_count   = r_count;
        w_product = r_product;
        w_done    = r_done;
        w_busy    = r_busy;
        case (r_state)
            IDLE: if (bus.start) begin
                w_mcand  = {{(PW-WIDTH){1'b0}}, bus.multiplicand};
                w_mplier = bus.multiplier;
                w_acc    = '0;
                w_count  = CW'(WIDTH);
                w_busy   = 1'b1;
                w_state  = RUN;
            end
            RUN: begin
                w_acc    = w_sum;
                w_mcand  = r_mcand << 1;
                w_mplier = r_mplier >> 1;
                w_count  = r_count - 1'b1;
                // last iteration publishes the sum including this cycle's partial product
                if (r_count == CW'(1)) begin
                    w_product = w_sum;
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_state   = DONE;
                end
            end
            DONE: if (!bus.start) begin
                w_done  = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.product = r_product;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
endmodule
